uart_rx_param: RTL

Parametrised serial UART receiver. It is the successor to the fixed 8-bit, one-sample-per-bit `serial_UART` receiver, and sits between the asynchronous RX pin and the byte-consumer logic. Compared with that block it adds:
- configurable data width, oversampling ratio and stop-bit count;
- an input synchroniser and mid-bit sampling with false-start rejection;
- framing-error detection, plus optional parity checking.

---
 rtl/uart_rx_param.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with input synchroniser, mid-bit sampling,
// false-start rejection and framing check. Define UART_RX_PARITY_EN to add a parity slot.
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  // The IDLE->START edge already consumes one cycle of the half-bit wait.
  localparam logic [CW-1:0] HALF_RELOAD = CW'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [3:0]    LAST_DATA   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP   = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic                 r_sync1, r_sync2;
  logic                 w_rx, w_tick;
  state_t               r_state, w_state_nx;
  logic [CW-1:0]        r_cnt, w_cnt_nx;
  logic [3:0]           r_idx, w_idx_nx;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic [DATA_BITS-1:0] r_data, w_data_nx;
  logic                 r_stop_bad, w_stop_bad_nx, w_stop_bad_now;
  logic                 r_valid, w_valid_nx;
  logic                 r_ferr, w_ferr_nx;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad, w_par_bad_nx;
  logic                 r_perr, w_perr_nx;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx   = r_sync2;
  assign w_tick = (r_cnt == '0);

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = w_tick ? BIT_RELOAD : r_cnt - CW'(1);
    w_idx_nx       = r_idx;
    w_shift_nx     = r_shift;
    w_data_nx      = r_data;
    w_stop_bad_nx  = r_stop_bad;
    w_stop_bad_now = r_stop_bad | ~w_rx;
    w_valid_nx     = 1'b0;
    w_ferr_nx      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_nx   = r_par_bad;
    w_perr_nx      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (!w_rx) begin
          w_idx_nx      = '0;
          w_stop_bad_nx = 1'b0;
          // With a zero half-bit wait the start sample is this very edge.
          if (HALF == 0) begin
            w_state_nx = S_DATA;
            w_cnt_nx   = BIT_RELOAD;
          end else begin
            w_state_nx = S_START;
            w_cnt_nx   = HALF_RELOAD;
          end
        end
      end
      S_START: begin
        if (w_tick) begin
          if (w_rx) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nx = {w_rx, r_shift[DATA_BITS-1:1]};
          if (r_idx == LAST_DATA) begin
            w_idx_nx = '0;
`ifdef UART_RX_PARITY_EN
            w_state_nx = S_PARITY;
`else
            w_state_nx = S_STOP;
`endif
          end else begin
            w_idx_nx = r_idx + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_par_bad_nx = ((^r_shift) ^ w_rx) != 1'(PARITY_ODD);
          w_state_nx   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          if (r_idx == LAST_STOP) begin
            w_cnt_nx = '0;
            w_idx_nx = '0;
            if (w_stop_bad_now) begin
              w_ferr_nx  = 1'b1;
              w_state_nx = S_WAIT_HIGH;
            end else begin
              w_valid_nx = 1'b1;
              w_data_nx  = r_shift;
`ifdef UART_RX_PARITY_EN
              w_perr_nx  = r_par_bad;
`endif
              w_state_nx = S_IDLE;
            end
          end else begin
            w_idx_nx      = r_idx + 4'd1;
            w_stop_bad_nx = w_stop_bad_now;
          end
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_nx = '0;
        if (w_rx) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_bad <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_idx      <= w_idx_nx;
      r_stop_bad <= w_stop_bad_nx;
      r_data     <= w_data_nx;
      r_valid    <= w_valid_nx;
      r_ferr     <= w_ferr_nx;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= w_par_bad_nx;
      r_perr     <= w_perr_nx;
`endif
    end
  end

  // Shift register holds data only; every bit is rewritten before it is delivered.
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nx;
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  logic w_unused_par;
  assign w_unused_par = 1'(PARITY_ODD);
  assign parity_err   = 1'b0;
`endif

endmodule
